// File: rtl/seq_divmod_if.sv
// Start/Busy/Done handshake bundle for the sequential unsigned divider.
interface seq_divmod_if #(
    parameter int unsigned WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             DivByZero;

    modport master (output Start, A, B, input Busy, Done, Q, R, DivByZero);
    modport slave  (input Start, A, B, output Busy, Done, Q, R, DivByZero);
endinterface

// File: rtl/seq_divmod.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// Q/R/DivByZero are held from the Done cycle until the next completion.
module seq_divmod #(
    parameter int unsigned WIDTH = 64
) (
    input logic         Clk,
    input logic         Rst,
    seq_divmod_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, dbz_q;

    logic             accept, b_zero, last;
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    // One restoring step; the dividend register fills with quotient bits from the LSB.
    always_comb begin
        rem_sh  = {rem_q, dvd_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, dvs_q};
        ge      = rem_sh[WIDTH] | ~diff[WIDTH];
        rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nxt = {dvd_q[WIDTH-2:0], ge};
    end

    // Next-state logic; a zero divisor skips RUN entirely.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        b_zero    = (bus.B == '0);
        last      = (cnt_q == CW'(1));
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.Start) begin
                    accept    = 1'b1;
                    state_nxt = b_zero ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Operand/shift registers and the held result registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            dbz_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == S_RUN);
            done_q <= (state_nxt == S_DONE);
            if (accept) begin
                dvd_q <= bus.A;
                dvs_q <= bus.B;
                rem_q <= '0;
                cnt_q <= CW'(WIDTH);
                if (b_zero) begin
                    q_q   <= '1;
                    r_q   <= bus.A;
                    dbz_q <= 1'b1;
                end
            end else if (state == S_RUN) begin
                dvd_q <= quo_nxt;
                rem_q <= rem_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (last) begin
                    q_q   <= quo_nxt;
                    r_q   <= rem_nxt;
                    dbz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.Q         = q_q;
    assign bus.R         = r_q;
    assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_seq_divmod.sv
// Bench for seq_divmod at WIDTH=8 (directed) and WIDTH=64 (random pairs),
// checked every cycle against a latency/arithmetic model.
module tb_seq_divmod;
    logic clk = 1'b0;
    logic rst8, rst64;
    always #5 clk = ~clk;

    seq_divmod_if #(.WIDTH(8))  i8 ();
    seq_divmod_if #(.WIDTH(64)) i64 ();

    seq_divmod #(.WIDTH(8))  u8  (.Clk(clk), .Rst(rst8),  .bus(i8));
    seq_divmod #(.WIDTH(64)) u64 (.Clk(clk), .Rst(rst64), .bus(i64));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [63:0] o_q [2], o_r [2], in_a [2], in_b [2];
    logic        o_busy [2], o_done [2], o_dbz [2], in_st [2], in_rst [2];

    assign o_q[0]    = {56'd0, i8.Q};
    assign o_r[0]    = {56'd0, i8.R};
    assign o_busy[0] = i8.Busy;
    assign o_done[0] = i8.Done;
    assign o_dbz[0]  = i8.DivByZero;
    assign in_a[0]   = {56'd0, i8.A};
    assign in_b[0]   = {56'd0, i8.B};
    assign in_st[0]  = i8.Start;
    assign in_rst[0] = rst8;
    assign o_q[1]    = i64.Q;
    assign o_r[1]    = i64.R;
    assign o_busy[1] = i64.Busy;
    assign o_done[1] = i64.Done;
    assign o_dbz[1]  = i64.DivByZero;
    assign in_a[1]   = i64.A;
    assign in_b[1]   = i64.B;
    assign in_st[1]  = i64.Start;
    assign in_rst[1] = rst64;

    // Model: accepted op finishes WIDTH edges later with A/B, A%B; B=0 finishes at once.
    logic [63:0] m_q [2], m_r [2], m_pq [2], m_pr [2];
    logic        m_busy [2], m_done [2], m_dbz [2];
    int          m_left [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (in_rst[d]) begin
                m_q[d] <= '0; m_r[d] <= '0; m_pq[d] <= '0; m_pr[d] <= '0;
                m_busy[d] <= 1'b0; m_done[d] <= 1'b0; m_dbz[d] <= 1'b0; m_left[d] <= 0;
            end else if (!m_busy[d] && in_st[d]) begin
                if (in_b[d] == 64'd0) begin
                    m_q[d]    <= (d == 0) ? 64'hFF : 64'hFFFF_FFFF_FFFF_FFFF;
                    m_r[d]    <= in_a[d];
                    m_dbz[d]  <= 1'b1;
                    m_done[d] <= 1'b1;
                end else begin
                    m_pq[d]   <= in_a[d] / in_b[d];
                    m_pr[d]   <= in_a[d] % in_b[d];
                    m_left[d] <= (d == 0) ? 8 : 64;
                    m_busy[d] <= 1'b1;
                    m_done[d] <= 1'b0;
                end
            end else if (m_busy[d]) begin
                m_left[d] <= m_left[d] - 1;
                if (m_left[d] == 1) begin
                    m_busy[d] <= 1'b0;
                    m_done[d] <= 1'b1;
                    m_q[d]    <= m_pq[d];
                    m_r[d]    <= m_pr[d];
                    m_dbz[d]  <= 1'b0;
                end
            end else begin
                m_done[d] <= 1'b0;
            end
        end
    end

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                cmp(d == 0 ? "w8 busy" : "w64 busy", 64'(o_busy[d]), 64'(m_busy[d]));
                cmp(d == 0 ? "w8 done" : "w64 done", 64'(o_done[d]), 64'(m_done[d]));
                cmp(d == 0 ? "w8 dbz"  : "w64 dbz",  64'(o_dbz[d]),  64'(m_dbz[d]));
                cmp(d == 0 ? "w8 Q"    : "w64 Q",    o_q[d], m_q[d]);
                cmp(d == 0 ? "w8 R"    : "w64 R",    o_r[d], m_r[d]);
            end
        end
    end

    task automatic set_in(input int d, input logic st, input logic [63:0] a, input logic [63:0] b);
        if (d == 0) begin
            i8.Start = st; i8.A = a[7:0]; i8.B = b[7:0];
        end else begin
            i64.Start = st; i64.A = a; i64.B = b;
        end
    endtask

    // Edges after the accepting edge until Done is seen; bc counts Busy cycles on the way.
    task automatic wait_done(input int d, output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!o_done[d] && lat < 300) begin
            if (o_busy[d]) bc++;
            @(negedge clk);
            lat++;
        end
        if (!o_done[d]) begin
            total++;
            bad++;
            $display("FAIL done timeout dut=%0d got=no Done want=Done within 300", d);
        end
    endtask

    task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output int bc);
        set_in(d, 1'b1, a, b);
        @(negedge clk);
        set_in(d, 1'b0, ~a, ~b);
        wait_done(d, lat, bc);
    endtask

    logic [63:0] ta [3] = '{64'd255, 64'd3,   64'd200};
    logic [63:0] tb [3] = '{64'd1,   64'd200, 64'd200};
    logic [63:0] tq [3] = '{64'd255, 64'd0,   64'd1};
    logic [63:0] tr [3] = '{64'd0,   64'd3,   64'd0};

    initial begin
        int lat, bc, ndone;
        logic [63:0] a, b;
        set_in(0, 1'b0, 64'd0, 64'd0);
        set_in(1, 1'b0, 64'd0, 64'd0);
        rst8 = 1'b1;
        rst64 = 1'b1;
        repeat (3) @(negedge clk);
        rst8 = 1'b0;
        rst64 = 1'b0;
        chk_en = 1'b1;
        cmp("reset busy", 64'(o_busy[0]), 64'd0);
        cmp("reset done", 64'(o_done[1]), 64'd0);
        cmp("reset Q", o_q[1], 64'd0);
        cmp("reset R", o_r[0], 64'd0);

        // 100 / 7
        run_op(0, 64'd100, 64'd7, lat, bc);
        cmp("t1 lat", 64'(lat), 64'd8);
        cmp("t1 busy cycles", 64'(bc), 64'd8);
        cmp("t1 Q", o_q[0], 64'd14);
        cmp("t1 R", o_r[0], 64'd2);
        cmp("t1 dbz", 64'(o_dbz[0]), 64'd0);
        repeat (5) @(negedge clk);
        cmp("t1 hold Q", o_q[0], 64'd14);
        cmp("t1 hold R", o_r[0], 64'd2);

        // 5 / 0
        run_op(0, 64'd5, 64'd0, lat, bc);
        cmp("t2 lat", 64'(lat), 64'd0);
        cmp("t2 busy cycles", 64'(bc), 64'd0);
        cmp("t2 Q", o_q[0], 64'd255);
        cmp("t2 R", o_r[0], 64'd5);
        cmp("t2 dbz", 64'(o_dbz[0]), 64'd1);
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb[i], lat, bc);
            cmp("t3 lat", 64'(lat), 64'd8);
            cmp("t3 Q", o_q[0], tq[i]);
            cmp("t3 R", o_r[0], tr[i]);
            @(negedge clk);
        end

        // Start during RUN ignored, then Start held through Done for back-to-back
        set_in(0, 1'b1, 64'd100, 64'd7);
        @(negedge clk);
        set_in(0, 1'b0, 64'd0, 64'd0);
        repeat (2) @(negedge clk);
        set_in(0, 1'b1, 64'd1, 64'd1);
        @(negedge clk);
        set_in(0, 1'b0, 64'd1, 64'd1);
        @(negedge clk);
        set_in(0, 1'b1, 64'd50, 64'd6);
        wait_done(0, lat, bc);
        cmp("t4 first Q", o_q[0], 64'd14);
        cmp("t4 first R", o_r[0], 64'd2);
        @(negedge clk);
        set_in(0, 1'b0, 64'd0, 64'd0);
        wait_done(0, lat, bc);
        cmp("t4 done spacing", 64'(lat + 1), 64'd9);
        cmp("t4 Q", o_q[0], 64'd8);
        cmp("t4 R", o_r[0], 64'd2);
        @(negedge clk);

        // Reset at RUN cycle 4
        set_in(0, 1'b1, 64'd100, 64'd7);
        @(negedge clk);
        set_in(0, 1'b0, 64'd0, 64'd0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        cmp("t5 busy", 64'(o_busy[0]), 64'd0);
        cmp("t5 Q", o_q[0], 64'd0);
        cmp("t5 R", o_r[0], 64'd0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_done[0]) ndone++;
        end
        cmp("t5 no done", 64'(ndone), 64'd0);
        run_op(0, 64'd9, 64'd4, lat, bc);
        cmp("t5 Q", o_q[0], 64'd2);
        cmp("t5 R", o_r[0], 64'd1);
        @(negedge clk);

        // 64-bit boundary and random pairs
        run_op(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, lat, bc);
        cmp("w64 lat", 64'(lat), 64'd64);
        cmp("w64 Q", o_q[1], 64'h0000_0000_FFFF_FFFF);
        cmp("w64 R", o_r[1], 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (i % 10)
                0: b = 64'd0;
                1: begin a = 64'($urandom_range(1000)); b = b | 64'h8000_0000_0000_0000; end
                2: b = 64'($urandom_range(255, 1));
                default: ;
            endcase
            run_op(1, a, b, lat, bc);
            cmp("rand lat", 64'(lat), (b == 64'd0) ? 64'd0 : 64'd64);
            cmp("rand busy cycles", 64'(bc), (b == 64'd0) ? 64'd0 : 64'd64);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
